// File: rtl/shiftin_rx.sv
// Fabric receiver for the 3-wire ser/sclk/lclk DAC link: oversamples the lines,
// shifts MSB-first on sclk rising edges and latches the word on lclk rising edges.
module shiftin_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       ser_i,
    input  logic                       sclk_i,
    input  logic                       lclk_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       data_rdy_o,
    output logic                       frame_err_o,
    output logic [$clog2(WIDTH+1)-1:0] bit_count_o,
    output logic                       busy_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL
    } state_e;

    // Synchroniser chain, one lane per line: {ser, sclk, lclk}.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic                        sclk_dly_q, lclk_dly_q;
    logic                        ser_s, sclk_s, lclk_s;
    logic                        sclk_rise, lclk_rise;

    state_e                      state_q, state_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        ovf_q, ovf_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic [TW-1:0]               tmo_inc;

    logic [WIDTH-1:0]            shreg_q, shreg_d;
    logic [WIDTH-1:0]            data_q, data_d;
    logic                        rdy_q, rdy_d;
    logic                        err_q, err_d;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], {ser_i, sclk_i, lclk_i}};
        ser_s     = sync_q[SYNC_STAGES-1][2];
        sclk_s    = sync_q[SYNC_STAGES-1][1];
        lclk_s    = sync_q[SYNC_STAGES-1][0];
        sclk_rise = sclk_s & ~sclk_dly_q;
        lclk_rise = lclk_s & ~lclk_dly_q;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic. A latch edge resets the frame first, so a coincident
    // shift edge then starts the next frame from IDLE.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise an
        // unassigned path infers a latch.
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        tmo_inc = tmo_q + TW'(1);

        if (lclk_rise) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            tmo_d   = '0;
        end

        if (sclk_rise) begin
            tmo_d = '0;
            unique case (lclk_rise ? IDLE : state_q)
                IDLE: begin
                    count_d = CW'(1);
                    state_d = (WIDTH == 1) ? FULL : SHIFT;
                end
                SHIFT: begin
                    count_d = count_q + CW'(1);
                    if (count_q + CW'(1) == CW'(WIDTH)) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    ovf_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (!lclk_rise && state_q != IDLE && TIMEOUT != 0) begin
            // Stale partial frame: drop the count, keep the shift register.
            if (tmo_inc == TW'(TIMEOUT)) begin
                state_d = IDLE;
                count_d = '0;
                ovf_d   = 1'b0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_inc;
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy_o = (state_q != IDLE);
    end

    // Datapath: the latch always takes the pre-shift register contents.
    always_comb begin
        shreg_d = sclk_rise ? {shreg_q[WIDTH-2:0], ser_s} : shreg_q;
        data_d  = lclk_rise ? shreg_q : data_q;
        rdy_d   = lclk_rise;
        err_d   = lclk_rise && ((count_q != CW'(WIDTH)) || ovf_q);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: synchroniser and edge flops are reset too, so no phantom edge
        // is seen on the first cycles after reset is released.
        if (reset_i) begin
            sync_q     <= '0;
            sclk_dly_q <= 1'b0;
            lclk_dly_q <= 1'b0;
            shreg_q    <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sclk_dly_q <= sclk_s;
            lclk_dly_q <= lclk_s;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    assign data_o      = data_q;
    assign data_rdy_o  = rdy_q;
    assign frame_err_o = err_q;
    assign bit_count_o = count_q;

endmodule
